// File: rtl/mod_rgf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among writeback sources,
// with a one-entry registered output stage that honours the pipeline hold.
module mod_rgf_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic                      hold_i,
  output logic                      rgf_write_o,
  output logic [ADDR_W-1:0]         rgf_write_addr_o,
  output logic [DATA_W-1:0]         rgf_write_data_o,
  output logic [1:0]                grant_id_o,
  output logic [31:0]               commit_count_o,
  output logic [31:0]               drop_count_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  // Handshake: a requester holds valid/addr/data stable until it sees its
  // ready bit high at a rising edge; that edge is the transfer.
  logic              out_valid_q, out_valid_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        id_q, id_d;
  logic [31:0]       commit_q, commit_d;
  logic [31:0]       drop_q, drop_d;

  logic              can_accept;
  logic              drain;
  logic              accept;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  next_ptr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  int                cand_int;

  assign can_accept = !out_valid_q || !hold_i;
  assign drain      = out_valid_q && !hold_i;

  // Scan from the round-robin pointer upward, wrapping at NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_int  = 0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_int = int'(rr_ptr_q) + off;
      if (cand_int >= NUM_REQ) begin
        cand_int = cand_int - NUM_REQ;
      end
      cand = PTR_W'(cand_int);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept   = win_found && can_accept && !reset;
  assign win_addr = req_addr_i[win_idx*ADDR_W +: ADDR_W];
  assign win_data = req_data_i[win_idx*DATA_W +: DATA_W];
  assign next_ptr = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[win_idx] = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    id_d        = id_q;
    commit_d    = commit_q;
    drop_d      = drop_q;
    if (drain) begin
      out_valid_d = 1'b0;
      commit_d    = commit_q + 32'd1;
    end
    // A $zero write is consumed like any other but never reaches the stage.
    if (accept) begin
      rr_ptr_d = next_ptr;
      if (win_addr != '0) begin
        out_valid_d = 1'b1;
        addr_d      = win_addr;
        data_d      = win_data;
        id_d        = 2'(win_idx);
      end else begin
        drop_d = drop_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      id_q        <= '0;
      commit_q    <= '0;
      drop_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      id_q        <= id_d;
      commit_q    <= commit_d;
      drop_q      <= drop_d;
    end
  end

  assign rgf_write_o      = out_valid_q;
  assign rgf_write_addr_o = addr_q;
  assign rgf_write_data_o = data_q;
  assign grant_id_o       = id_q;
  assign commit_count_o   = commit_q;
  assign drop_count_o     = drop_q;

endmodule

// File: tb/tb_mod_rgf_write_arbiter.sv
// Bench for mod_rgf_write_arbiter: directed scenarios followed by random traffic,
// checked against a queue-based reference of committed writes.
module tb_mod_rgf_write_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            hold;
  logic            rgf_write;
  logic [AW-1:0]   rgf_addr;
  logic [DW-1:0]   rgf_data;
  logic [1:0]      grant_id;
  logic [31:0]     commit_count;
  logic [31:0]     drop_count;

  mod_rgf_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid),
    .req_addr_i       (req_addr),
    .req_data_i       (req_data),
    .req_ready_o      (req_ready),
    .hold_i           (hold),
    .rgf_write_o      (rgf_write),
    .rgf_write_addr_o (rgf_addr),
    .rgf_write_data_o (rgf_data),
    .grant_id_o       (grant_id),
    .commit_count_o   (commit_count),
    .drop_count_o     (drop_count)
  );

  always #5 clk = ~clk;

  // Reference: staged write, pointer, counters, and queue of writes yet to commit.
  int                 checks = 0;
  int                 errors = 0;
  bit                 m_valid = 0;
  int                 m_ptr = 0;
  int                 m_id = 0;
  logic [AW-1:0]      m_addr = '0;
  logic [DW-1:0]      m_data = '0;
  logic [31:0]        m_commit = '0;
  logic [31:0]        m_drop = '0;
  logic [AW+DW-1:0]   exp_q[$];
  logic [N-1:0]       last_acc;
  logic [N-1:0]       obs_ready;
  int                 wait_cnt[N];
  logic [31:0]        saved;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]        = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic release_accepted();
    for (int i = 0; i < N; i++) if (last_acc[i]) req_valid[i] = 1'b0;
  endtask

  task automatic step();
    int win;
    bit can;
    bit drain;
    logic [N-1:0] exp_ready;
    logic [AW-1:0] a;
    @(negedge clk);
    can = !m_valid || !hold;
    win = -1;
    for (int off = 0; off < N; off++) begin
      if (win < 0 && req_valid[(m_ptr + off) % N]) win = (m_ptr + off) % N;
    end
    exp_ready = '0;
    if (can && win >= 0 && !reset) exp_ready[win] = 1'b1;
    obs_ready = req_ready;
    check("req_ready", req_ready, exp_ready);
    check("rgf_write_pre", rgf_write, m_valid);
    drain = m_valid && !hold && !reset;
    if (drain) begin
      check("commit_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("commit_write", {rgf_addr, rgf_data}, exp_q.pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || reset) wait_cnt[i] = 0;
      else if (exp_ready[i]) begin
        check("fairness", wait_cnt[i] < N, 1);
        wait_cnt[i] = 0;
      end else if (can) wait_cnt[i]++;
    end
    last_acc = exp_ready;
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_ptr = 0; m_id = 0; m_addr = '0; m_data = '0;
      m_commit = '0; m_drop = '0;
      exp_q.delete();
    end else begin
      if (drain) begin
        m_commit = m_commit + 1;
        m_valid  = 0;
      end
      if (exp_ready != '0) begin
        m_ptr = (win + 1) % N;
        a = req_addr[win*AW +: AW];
        if (a != '0) begin
          m_valid = 1;
          m_addr  = a;
          m_data  = req_data[win*DW +: DW];
          m_id    = win;
          exp_q.push_back({m_addr, m_data});
        end else begin
          m_drop = m_drop + 1;
        end
      end
    end
    #1;
    check("rgf_write", rgf_write, m_valid);
    if (m_valid) begin
      check("rgf_addr", rgf_addr, m_addr);
      check("rgf_data", rgf_data, m_data);
      check("grant_id", grant_id, m_id);
    end
    check("commit_count", commit_count, m_commit);
    check("drop_count", drop_count, m_drop);
  endtask

  initial begin
    reset = 1'b1;
    hold = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    last_acc = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;

    // Reset with every requester valid: nothing may be accepted.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), $urandom);
    @(posedge clk); @(posedge clk); #1;
    step();
    check("t1_ready_in_reset", obs_ready, 3'b000);
    check("t1_addr_reset", rgf_addr, 0);
    check("t1_data_reset", rgf_data, 0);
    check("t1_grant_reset", grant_id, 0);
    reset = 1'b0;
    req_valid = '0;
    step();
    check("t1_write", rgf_write, 0);
    check("t1_commit", commit_count, 0);
    check("t1_drop", drop_count, 0);

    // Single load-unit write.
    set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
    step();
    check("t2_ready", obs_ready, 3'b010);
    check("t2_write", rgf_write, 1);
    check("t2_addr", rgf_addr, 5);
    check("t2_data", rgf_data, 32'hDEADBEEF);
    check("t2_grant", grant_id, 1);
    release_accepted();
    step();
    check("t2_ready_after", obs_ready, 3'b000);
    check("t2_commit", commit_count, 1);
    check("t2_write_idle", rgf_write, 0);

    // Back-to-back round robin from a fresh pointer.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), $urandom);
    for (int k = 0; k < 6; k++) begin
      step();
      check("t3_grant", grant_id, k % 3);
      check("t3_write", rgf_write, 1);
      for (int i = 0; i < N; i++) if (last_acc[i]) req_data[i*DW +: DW] = $urandom;
    end
    req_valid = '0;
    step();
    check("t3_commit", commit_count, 6);

    // Hold freezes the staged write; release commits and refills on one edge.
    set_req(0, 1'b1, 5'd7, $urandom);
    step();
    release_accepted();
    hold = 1'b1;
    set_req(2, 1'b1, 5'd9, $urandom);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t4_ready_held", obs_ready, 3'b000);
      check("t4_write_held", rgf_write, 1);
      check("t4_addr_held", rgf_addr, 7);
    end
    hold = 1'b0;
    step();
    check("t4_ready_release", obs_ready, 3'b100);
    check("t4_commit", commit_count, 7);
    check("t4_grant", grant_id, 2);
    release_accepted();
    step();

    // Write to $zero is consumed and discarded.
    saved = commit_count;
    set_req(2, 1'b1, 5'd0, 32'h1234);
    step();
    check("t5_ready", obs_ready, 3'b100);
    check("t5_write", rgf_write, 0);
    check("t5_drop", drop_count, 1);
    check("t5_commit", commit_count, saved);
    release_accepted();

    // Reset drops a staged write.
    set_req(1, 1'b1, 5'd4, $urandom);
    step();
    release_accepted();
    reset = 1'b1;
    step();
    check("t6_write", rgf_write, 0);
    check("t6_commit", commit_count, 0);
    reset = 1'b0;
    step();
    check("t6_commit_after", commit_count, 0);

    // Random traffic with random hold.
    for (int c = 0; c < 500; c++) begin
      release_accepted();
      hold = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'b1, ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31)), $urandom);
      end
      step();
    end
    release_accepted();
    hold = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      release_accepted();
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
